// File: rtl/spi_regfile.sv
// spi_regfile: SPI-side register file with write/read FSM and serial read-back shifter.
// Ports: spi_clk/rst (sync, active-high), cs chip select, byte_done pulse with is_write/addr/wdata
// from the address stage, status_in (read-only at 7'h7F), poci serial read data (MSB first),
// cfg_out packed config registers, wr_pulse/wr_addr strobe and target of each accepted write.
module spi_regfile #(
  parameter int          NUM_REGS  = 32,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  spi_clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  byte_done,
  input  logic                  is_write,
  input  logic [6:0]            addr,
  input  logic [7:0]            wdata,
  input  logic [7:0]            status_in,
  output logic                  poci,
  output logic [NUM_REGS*8-1:0] cfg_out,
  output logic                  wr_pulse,
  output logic [6:0]            wr_addr
);
  typedef enum logic [1:0] {IDLE, HDR, WR, RD} state_t;
  localparam logic [6:0] NR = 7'(NUM_REGS);
  state_t      state_q, state_d;
  logic        bd_q, bd_d;
  logic        arm_q, arm_d;
  logic [7:0]  sh_q, sh_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  rmap [128];
  logic        sample, wr_en, load;
  logic [6:0]  tgt;
  logic [7:0]  rd_val;
  // Full 128-entry read map so the address can index it directly.
  for (genvar g = 0; g < 128; g++) begin : g_map
    if (g < NUM_REGS) begin : g_reg
      assign rmap[g] = regs_q[g];
      assign cfg_out[g*8 +: 8] = regs_q[g];
    end else if (g == 127) begin : g_stat
      assign rmap[g] = status_in;
    end else begin : g_zero
      assign rmap[g] = 8'h00;
    end
  end
  assign sample = bd_q & cs & (state_q != IDLE);
  // Upstream has already post-incremented addr for data bytes.
  assign tgt    = addr - 7'd1;
  assign wr_en  = sample & (state_q == WR) & (tgt < NR);
  assign load   = sample & (((state_q == HDR) & ~is_write) | (state_q == RD));
  assign rd_val = rmap[addr];
  assign poci     = (state_q == RD) & sh_q[7];
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  always_comb begin
    state_d = state_q;
    if (!cs) state_d = IDLE;
    else if (state_q == IDLE && arm_q) state_d = HDR;
    else if (state_q == HDR && sample) state_d = is_write ? WR : RD;
    bd_d       = byte_done & cs & (state_q != IDLE);
    // After reset, cs must be seen low before a new transaction may start.
    arm_d      = ~cs | arm_q;
    sh_d       = load ? rd_val : (cs && state_q == RD) ? {sh_q[6:0], 1'b0} : sh_q;
    wr_pulse_d = wr_en;
    wr_addr_d  = wr_en ? tgt : wr_addr_q;
  end
  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bd_q       <= 1'b0;
      arm_q      <= 1'b0;
      sh_q       <= 8'h00;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 7'h00;
    end else begin
      state_q    <= state_d;
      bd_q       <= bd_d;
      arm_q      <= arm_d;
      sh_q       <= sh_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
    end
  end
  always_ff @(posedge spi_clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) regs_q[i] <= RESET_VAL;
      else if (wr_en && tgt == 7'(i)) regs_q[i] <= wdata;
    end
  end
endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: randomized and directed checks of spi_regfile against a transaction-level model.
module tb_spi_regfile;
  localparam int         NR = 32;
  localparam logic [7:0] RV = 8'hA5;
  logic            spi_clk = 0;
  logic            rst = 1, cs = 0, byte_done = 0, is_write = 0;
  logic [6:0]      addr = 0;
  logic [7:0]      wdata = 0, status_in = 0;
  logic            poci, wr_pulse;
  logic [NR*8-1:0] cfg_out;
  logic [6:0]      wr_addr;
  int              n_checks = 0, n_errors = 0;
  logic [7:0]      m [128];
  logic [6:0]      m_wa;
  logic [7:0]      data_q [$];

  spi_regfile #(.NUM_REGS(NR), .RESET_VAL(RV)) dut (
    .spi_clk(spi_clk), .rst(rst), .cs(cs), .byte_done(byte_done), .is_write(is_write),
    .addr(addr), .wdata(wdata), .status_in(status_in), .poci(poci), .cfg_out(cfg_out),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge spi_clk);
    #1;
  endtask

  function automatic logic [7:0] rd_m(input logic [6:0] a);
    return (a < NR) ? m[a] : (a == 7'h7F) ? status_in : 8'h00;
  endfunction

  function automatic logic [255:0] exp_cfg();
    logic [255:0] v = '0;
    for (int i = 0; i < NR; i++) v[i*8 +: 8] = m[i];
    return v;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 128; i++) m[i] = RV;
    m_wa = 7'h00;
  endtask

  task automatic send_byte(input logic w, input logic [6:0] a, input logic [7:0] d);
    is_write = w; addr = a; wdata = d; byte_done = 1;
    tick;
    byte_done = 0;
    tick;
  endtask

  task automatic check_read(input logic [6:0] a);
    logic [7:0] b = rd_m(a);
    for (int i = 0; i < 8; i++) begin
      check("poci_bit", poci, b[7-i]);
      tick;
    end
  endtask

  task automatic xact(input logic w, input logic [6:0] a0, input int nbytes);
    logic [6:0] a, t;
    logic [7:0] d;
    logic       acc;
    cs = 1;
    tick;
    send_byte(w, a0, 8'($urandom));
    if (w) check("hdr_no_wr", wr_pulse, 1'b0);
    else check_read(a0);
    for (int i = 1; i <= nbytes; i++) begin
      a = a0 + 7'(i);
      if (w) begin
        d = data_q.size() > 0 ? data_q.pop_front() : 8'($urandom);
        send_byte(1'b1, a, d);
        t = a - 7'd1;
        acc = (t < NR);
        if (acc) begin m[t] = d; m_wa = t; end
        check("wr_pulse", wr_pulse, acc);
        check("wr_addr", wr_addr, m_wa);
        check("cfg_wr", cfg_out, exp_cfg());
        tick;
        check("wr_pulse_end", wr_pulse, 1'b0);
      end else begin
        send_byte(1'b0, a, 8'($urandom));
        check_read(a);
      end
    end
    cs = 0;
    tick;
    tick;
    check("poci_idle", poci, 1'b0);
    check("cfg_idle", cfg_out, exp_cfg());
  endtask

  initial begin
    logic [6:0] a0;
    model_reset();
    tick; tick;
    rst = 0;
    check("rst_cfg", cfg_out, exp_cfg());
    check("rst_poci", poci, 1'b0);
    check("rst_wp", wr_pulse, 1'b0);
    check("rst_wa", wr_addr, 7'h00);
    tick;
    // burst write
    data_q = '{8'hA1, 8'hB2};
    xact(1'b1, 7'd5, 2);
    check("reg5", cfg_out[47:40], 8'hA1);
    check("reg6", cfg_out[55:48], 8'hB2);
    check("wa_last", wr_addr, 7'd6);
    // read 0x5C from reg3
    data_q = '{8'h5C};
    xact(1'b1, 7'd3, 1);
    xact(1'b0, 7'd3, 0);
    // status and unmapped
    status_in = 8'h3E;
    xact(1'b0, 7'h7F, 0);
    xact(1'b0, 7'h40, 0);
    xact(1'b1, 7'h40, 1);
    check("wa_unmapped", wr_addr, 7'd3);
    // wrap: T=7F dropped, then reg0 = 77
    data_q = '{8'h11, 8'h77};
    xact(1'b1, 7'h7F, 2);
    check("reg0", cfg_out[7:0], 8'h77);
    check("wa_wrap", wr_addr, 7'd0);
    // byte_done coincident with cs falling
    cs = 1; tick;
    send_byte(1'b1, 7'd10, 8'h00);
    is_write = 1; addr = 7'd11; wdata = 8'hFF; byte_done = 1; cs = 0;
    tick; byte_done = 0; tick; tick;
    check("abort1_wp", wr_pulse, 1'b0);
    check("abort1_cfg", cfg_out, exp_cfg());
    // byte_done_d arrives with cs already low
    cs = 1; tick;
    send_byte(1'b1, 7'd10, 8'h00);
    addr = 7'd11; wdata = 8'hEE; byte_done = 1;
    tick; byte_done = 0; cs = 0;
    tick; tick;
    check("abort2_wp", wr_pulse, 1'b0);
    check("abort2_cfg", cfg_out, exp_cfg());
    // reset during WR
    cs = 1; tick;
    send_byte(1'b1, 7'd8, 8'h00);
    send_byte(1'b1, 7'd9, 8'hC3);
    check("pre_rst_reg8", cfg_out[71:64], 8'hC3);
    rst = 1; tick; rst = 0;
    model_reset();
    check("mid_rst_cfg", cfg_out, exp_cfg());
    check("mid_rst_poci", poci, 1'b0);
    check("mid_rst_wp", wr_pulse, 1'b0);
    check("mid_rst_wa", wr_addr, 7'h00);
    // cs still high: bytes must be ignored until cs cycles low
    tick;
    send_byte(1'b1, 7'd4, 8'hFF);
    send_byte(1'b1, 7'd5, 8'hFF);
    check("post_rst_wp", wr_pulse, 1'b0);
    check("post_rst_cfg", cfg_out, exp_cfg());
    cs = 0; tick;
    // randomized transactions
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0: a0 = 7'h7F;
        1: a0 = 7'(NR - 1);
        2: a0 = 7'(NR);
        default: a0 = 7'($urandom_range(0, NR + 3));
      endcase
      if ($urandom_range(0, 5) == 0) a0 = 7'($urandom);
      status_in = 8'($urandom);
      xact(1'($urandom), a0, $urandom_range(0, 4));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 Parameter NUM_REGS, default 32: number of read/write 8-bit config registers, at addresses 0..NUM_REGS-1, range 1..127.
REQ-002 Parameter RESET_VAL, default 8'h00: reset value of every config register.
REQ-003 spi_clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cs  input  1  chip select, high = transaction active.
REQ-006 byte_done  input  1  one-cycle pulse from the address stage when is_write/addr/wdata have just updated for a completed byte.
REQ-007 is_write  input  1  transaction direction, 1 = write.
REQ-008 addr  input  7  current address from the address stage; already post-incremented on data bytes.
REQ-009 wdata  input  8  last received data byte.
REQ-010 status_in  input  8  read-only status byte, mapped at address 7'h7F.
REQ-011 poci  output  1  serial read data, MSB first.
REQ-012 cfg_out  output  NUM_REGS*8  all config registers; register n at bits [8n+7:8n].
REQ-013 wr_pulse  output  1  one-cycle strobe per accepted register write.
REQ-014 wr_addr  output  7  address of the most recent accepted write.

Function
REQ-015 The block SHALL register byte_done into byte_done_d and sample is_write/addr/wdata only on cycles where byte_done_d=1 (the "sample cycle").
REQ-016 The FSM SHALL have states IDLE, HDR, WR, RD.
- IDLE -> HDR when cs=1.
- HDR -> WR or RD on the first sample cycle, per is_write.
- WR/RD hold until cs=0.
- Any state -> IDLE on the cycle after cs is sampled 0.
REQ-017 In IDLE, or on any cycle with cs=0, byte_done and byte_done_d SHALL be ignored.
REQ-018 The HDR sample cycle SHALL perform no register write.
REQ-019 Each WR sample cycle SHALL write wdata to target T = (addr - 1) mod 128, since the upstream stage has already incremented addr.
REQ-020 A write SHALL be accepted only if T < NUM_REGS.
- Accepted: register T updates at the end of the sample cycle, wr_pulse=1 the next cycle, and wr_addr=T.
- T = 7'h7F or T >= NUM_REGS: dropped silently; no wr_pulse; wr_addr unchanged.
REQ-021 Read mapping rd(a):
- a < NUM_REGS: register a.
- a = 7'h7F: status_in, sampled at the load cycle.
- otherwise: 8'h00.
REQ-022 8-bit shift register sh and poci = sh[7].
- HDR sample cycle with is_write=0, and every RD sample cycle: sh loads rd(addr).
- All other cycles with cs=1 and state RD: sh shifts left, filling 0.
- All other cycles: sh holds.
REQ-023 Address arithmetic SHALL wrap modulo 128: a WR sample with addr=7'h00 targets 7'h7F (dropped).
REQ-024 A cs deassertion mid-byte (byte_done never arrives) SHALL produce no write and leave all registers unchanged.
REQ-025 If byte_done_d=1 and cs=0 in the same cycle, the sample SHALL be discarded.
REQ-026 poci SHALL be 0 whenever state is not RD.

Reset
REQ-027 On rst=1 at a clock edge:
- every config register = RESET_VAL;
- state = IDLE, sh = 8'h00, byte_done_d = 0;
- wr_pulse = 0, wr_addr = 7'h00, poci = 0.
REQ-028 rst SHALL take priority over cs, byte_done and every other input.
REQ-029 rst asserted mid-transaction SHALL abort it; the block SHALL remain in IDLE until cs is seen low then high again.

Verification
REQ-030 Write burst: cs=1, header (is_write=1, addr=5), then data 8'hA1 (addr=6) and 8'hB2 (addr=7) -> reg5=A1, reg6=B2, two wr_pulses with wr_addr=5 then 6.
REQ-031 Read: reg3=8'h5C; header (is_write=0, addr=3) -> sh loads 5C; poci over the next 8 RD cycles = 0,1,0,1,1,1,0,0.
REQ-032 Status/unmapped: read header addr=7'h7F with status_in=8'h3E -> shifts 3E; read header addr=7'h40 (NUM_REGS=32) -> shifts 00; write to T=7'h40 -> no wr_pulse, cfg_out unchanged.
REQ-033 Wrap: write header addr=7'h7F, then data addr=7'h00 (T=7F, dropped), then data 8'h77 with addr=7'h01 -> reg0=77, single wr_pulse, wr_addr=0.
REQ-034 Abort: byte_done pulse coincident with cs falling -> no write; rst asserted during WR -> all cfg_out = RESET_VAL, state IDLE, poci=0 the next cycle.
